// File: rtl/mem_port_arbiter_pkg.sv
// Shared pipeline definitions for the instruction/data memory-port arbiter:
// data width, starvation-limit default, FSM and owner encodings.
package mem_port_arbiter_pkg;

    localparam int unsigned XLEN               = 32;
    localparam int unsigned StarveLimitDefault = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } arb_state_e;

    typedef enum logic {
        OwnFetch = 1'b0,
        OwnData  = 1'b1
    } owner_e;

    // Everything latched at grant time; the bus is driven only from this.
    typedef struct packed {
        owner_e          owner;
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [3:0]      wstrb;
    } bus_txn_t;

    // Counter width able to hold 0..limit (never narrower than one bit).
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and memory stages onto one shared memory bus.
// Data requests win unless fetch has waited through STARVE_LIMIT data grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_valid,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    input  logic [3:0]      dm_wstrb,
    output logic [XLEN-1:0] dm_rdata,
    output logic            dm_done,
    output logic            stall_f,
    output logic            stall_m,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_wstrb,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_ack
);

    localparam int unsigned    CntW   = cnt_width(STARVE_LIMIT);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    arb_state_e      state_q, state_d;
    bus_txn_t        txn_q, txn_d;
    logic            bus_req_q, bus_req_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] dm_rdata_q, dm_rdata_d;
    logic            if_valid_q, if_valid_d;
    logic            dm_done_q, dm_done_d;
    logic [CntW-1:0] starve_q, starve_d;

    logic fetch_starved;
    logic grant_data;
    logic grant_fetch;

    // Grant decode; only meaningful while idle.
    always_comb begin
        fetch_starved = if_req && (starve_q == CntMax);
        grant_data    = (state_q == StIdle) && dm_req && !fetch_starved;
        grant_fetch   = (state_q == StIdle) && if_req && !grant_data;
    end

    // Next-state, transaction latch, read-data capture and completion pulses.
    always_comb begin
        state_d    = state_q;
        txn_d      = txn_q;
        bus_req_d  = bus_req_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_valid_d = 1'b0;
        dm_done_d  = 1'b0;
        starve_d   = starve_q;

        unique case (state_q)
            StIdle: begin
                if (grant_data) begin
                    txn_d.owner = OwnData;
                    txn_d.we    = dm_we;
                    txn_d.addr  = dm_addr;
                    txn_d.wdata = dm_we ? dm_wdata : '0;
                    txn_d.wstrb = dm_we ? dm_wstrb : 4'b0000;
                    state_d     = StBusy;
                    bus_req_d   = 1'b1;
                    if (!if_req) begin
                        starve_d = '0;
                    end else if (starve_q != CntMax) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (grant_fetch) begin
                    txn_d.owner = OwnFetch;
                    txn_d.we    = 1'b0;
                    txn_d.addr  = if_addr;
                    txn_d.wdata = '0;
                    txn_d.wstrb = 4'b0000;
                    state_d     = StBusy;
                    bus_req_d   = 1'b1;
                    starve_d    = '0;
                end else if (!if_req) begin
                    starve_d = '0;
                end
            end
            StBusy: begin
                if (bus_ack) begin
                    state_d   = StResp;
                    bus_req_d = 1'b0;
                    if (txn_q.owner == OwnFetch) begin
                        if_rdata_d = bus_rdata;
                        if_valid_d = 1'b1;
                    end else begin
                        dm_done_d = 1'b1;
                        // Stores leave the last load result intact.
                        if (!txn_q.we) begin
                            dm_rdata_d = bus_rdata;
                        end
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d   = StIdle;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            txn_q      <= '0;
            bus_req_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_valid_q <= 1'b0;
            dm_done_q  <= 1'b0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            txn_q      <= txn_d;
            bus_req_q  <= bus_req_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_valid_q <= if_valid_d;
            dm_done_q  <= dm_done_d;
            starve_q   <= starve_d;
        end
    end

    // Outputs come straight from registers; stalls combine live requests.
    always_comb begin
        bus_req   = bus_req_q;
        bus_we    = txn_q.we;
        bus_addr  = txn_q.addr;
        bus_wdata = txn_q.wdata;
        bus_wstrb = txn_q.wstrb;
        if_rdata  = if_rdata_q;
        dm_rdata  = dm_rdata_q;
        if_valid  = if_valid_q;
        dm_done   = dm_done_q;
        stall_f   = if_req & ~if_valid_q;
        stall_m   = dm_req & ~dm_done_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: queue-fed requesters, a latency-programmable
// memory responder, and a scoreboard of expected bus transactions/responses.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    typedef struct {
        logic        is_fetch;
        logic        is_store;
        logic [31:0] rdata;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [3:0]  dm_wstrb = '0;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        stall_f;
    logic        stall_m;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_wstrb (dm_wstrb),
        .dm_rdata (dm_rdata),
        .dm_done  (dm_done),
        .stall_f  (stall_f),
        .stall_m  (stall_m),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] fq[$];
    txn_t        dq[$];
    txn_t        exp_bus[$];
    resp_t       exp_resp[$];

    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_dm_rdata = '0;

    int          ack_lat = 0;
    int          wait_n = 0;
    logic        acked = 1'b0;
    logic        resp_ack = 1'b0;
    logic        stray_ack = 1'b0;
    logic [31:0] resp_rdata = '0;

    assign bus_ack   = resp_ack | stray_ack;
    assign bus_rdata = resp_rdata;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h0000_0093;
        return (a * 32'd7) + 32'h1000_0001;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Memory responder: ack ack_lat cycles after bus_req is first seen.
    always @(negedge clk) begin
        if (!bus_req) begin
            resp_ack = 1'b0;
            wait_n   = 0;
            acked    = 1'b0;
        end else if (acked) begin
            resp_ack = 1'b0;
        end else if (wait_n == ack_lat) begin
            resp_ack   = 1'b1;
            resp_rdata = mem_word(bus_addr);
            acked      = 1'b1;
        end else begin
            wait_n++;
        end
    end

    int    cyc = 0;
    int    last_rise = -100;
    logic  prev_req = 1'b0;
    txn_t  cur;
    resp_t r;
    logic  have_r;

    // Scoreboard checks first, then requesters update their inputs.
    always @(negedge clk) begin
        cyc++;
        have_r = 1'b0;
        if (!rst) begin
            if (bus_req && !prev_req) begin
                check("grant_spacing", 32'(cyc - last_rise >= 3), 32'd1);
                last_rise = cyc;
                check("bus_expected", 32'(exp_bus.size() != 0), 32'd1);
                if (exp_bus.size() != 0) begin
                    cur = exp_bus.pop_front();
                    check("bus_addr", bus_addr, cur.addr);
                    check("bus_we", 32'(bus_we), 32'(cur.we));
                    check("bus_wstrb", 32'(bus_wstrb), 32'(cur.wstrb));
                    if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
                end
            end else if (bus_req) begin
                check("bus_addr_stable", bus_addr, cur.addr);
                check("bus_we_stable", 32'(bus_we), 32'(cur.we));
                check("bus_wstrb_stable", 32'(bus_wstrb), 32'(cur.wstrb));
                if (cur.we) check("bus_wdata_stable", bus_wdata, cur.wdata);
            end
            if (if_valid || dm_done) begin
                check("single_pulse", 32'(if_valid && dm_done), 32'd0);
                check("resp_expected", 32'(exp_resp.size() != 0), 32'd1);
                if (exp_resp.size() != 0) begin
                    r = exp_resp.pop_front();
                    have_r = 1'b1;
                    check("resp_owner", 32'(if_valid), 32'(r.is_fetch));
                    if (r.is_fetch) m_if_rdata = r.rdata;
                    else if (!r.is_store) m_dm_rdata = r.rdata;
                    check("if_rdata", if_rdata, m_if_rdata);
                    check("dm_rdata", dm_rdata, m_dm_rdata);
                end
            end
            check("stall_f", 32'(stall_f), 32'(if_req && !(have_r && r.is_fetch)));
            check("stall_m", 32'(stall_m), 32'(dm_req && !(have_r && !r.is_fetch)));
        end
        prev_req = bus_req;

        if (if_valid && fq.size() != 0) void'(fq.pop_front());
        if (dm_done && dq.size() != 0) void'(dq.pop_front());
        if (fq.size() != 0) begin
            if_req  = 1'b1;
            if_addr = fq[0];
        end else begin
            if_req = 1'b0;
        end
        if (dq.size() != 0) begin
            dm_req   = 1'b1;
            dm_we    = dq[0].we;
            dm_addr  = dq[0].addr;
            dm_wdata = dq[0].wdata;
            dm_wstrb = dq[0].wstrb;
        end else begin
            dm_req = 1'b0;
        end
    end

    task automatic push_fetch(input logic [31:0] a);
        txn_t  t;
        resp_t rr;
        fq.push_back(a);
        t.we = 1'b0; t.addr = a; t.wdata = '0; t.wstrb = 4'b0000;
        exp_bus.push_back(t);
        rr.is_fetch = 1'b1; rr.is_store = 1'b0; rr.rdata = mem_word(a);
        exp_resp.push_back(rr);
    endtask

    task automatic push_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] ws);
        txn_t  t;
        resp_t rr;
        t.we = we; t.addr = a; t.wdata = wd; t.wstrb = we ? ws : 4'b0000;
        dq.push_back(t);
        exp_bus.push_back(t);
        rr.is_fetch = 1'b0; rr.is_store = we; rr.rdata = we ? 32'h0 : mem_word(a);
        exp_resp.push_back(rr);
    endtask

    // The DUT does not see queue order; pushing in expected grant order is
    // only used for the scoreboard, requesters present both heads at once.
    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((fq.size() + dq.size() + exp_resp.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(fq.size() + dq.size() + exp_resp.size() + exp_bus.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_dm_done", 32'(dm_done), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(StIdle));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fetch only, ack two cycles after bus_req.
        ack_lat = 2;
        push_fetch(32'h0000_0010);
        drain("fetch_only_drain", 40);
        check("fetch_only_rdata", if_rdata, 32'h0000_0093);

        // Simultaneous requests: data first, then fetch.
        ack_lat = 1;
        push_data(1'b0, 32'h0000_0100, 32'h0, 4'h0);
        push_fetch(32'h0000_0014);
        drain("simultaneous_drain", 60);

        // Starvation: 4 data grants, one fetch, then the remaining data.
        ack_lat = 0;
        for (int i = 0; i < 4; i++) push_data(1'b0, 32'h300 + 32'(i * 4), 32'h0, 4'h0);
        push_fetch(32'h0000_0040);
        push_data(1'b0, 32'h310, 32'h0, 4'h0);
        push_data(1'b0, 32'h314, 32'h0, 4'h0);
        // Requesters need the full load list queued up front.
        dq.delete();
        for (int i = 0; i < 6; i++) begin
            txn_t t;
            t.we = 1'b0; t.addr = 32'h300 + 32'(i * 4); t.wdata = '0; t.wstrb = '0;
            dq.push_back(t);
        end
        drain("starve_drain", 120);

        // Store with immediate ack; last load data must survive.
        ack_lat = 0;
        push_data(1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011);
        drain("store_drain", 40);
        check("store_dm_rdata_kept", dm_rdata, mem_word(32'h314));

        // Reset while BUSY, then a stray ack.
        ack_lat = 1000;
        begin
            txn_t t;
            fq.push_back(32'h0000_0080);
            t.we = 1'b0; t.addr = 32'h80; t.wdata = '0; t.wstrb = '0;
            exp_bus.push_back(t);
        end
        n = 0;
        while (!bus_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_busy_reached", 32'(bus_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        fq.delete();
        m_if_rdata = '0;
        m_dm_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stray_ack = 1'b1;
        check("mid_rst_bus_req", 32'(bus_req), 32'd0);
        check("mid_rst_bus_addr", bus_addr, 32'd0);
        check("mid_rst_if_rdata", if_rdata, 32'd0);
        check("mid_rst_dm_rdata", dm_rdata, 32'd0);
        @(negedge clk);
        stray_ack = 1'b0;
        check("stray_bus_req", 32'(bus_req), 32'd0);
        check("stray_if_valid", 32'(if_valid), 32'd0);
        check("stray_dm_done", 32'(dm_done), 32'd0);
        check("stray_state", 32'(dut.state_q), 32'(StIdle));
        repeat (3) @(negedge clk);
        check("stray_no_pulse", 32'(if_valid | dm_done), 32'd0);

        // Recovery after reset.
        ack_lat = 1;
        push_fetch(32'h0000_0020);
        drain("recover_drain", 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive data grants while a fetch request waits.
REQ-002 SHALL have port clk  in  1  the single clock; every register samples on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port if_req  in  1  fetch-stage read request, held high until served.
REQ-005 SHALL have port if_addr  in  32  fetch address.
REQ-006 SHALL have port if_rdata  out  32  fetched instruction.
REQ-007 SHALL have port if_valid  out  1  one-cycle fetch-completion pulse.
REQ-008 SHALL have port dm_req  in  1  memory-stage request, held high until served.
REQ-009 SHALL have port dm_we  in  1  1 = store, 0 = load.
REQ-010 SHALL have port dm_addr  in  32  data address.
REQ-011 SHALL have port dm_wdata  in  32  store data.
REQ-012 SHALL have port dm_wstrb  in  4  store byte enables.
REQ-013 SHALL have port dm_rdata  out  32  load data.
REQ-014 SHALL have port dm_done  out  1  one-cycle data-completion pulse.
REQ-015 SHALL have port stall_f  out  1  fetch stall.
REQ-016 SHALL have port stall_m  out  1  memory-stage stall.
REQ-017 SHALL have port bus_req  out  1  shared-memory request.
REQ-018 SHALL have port bus_we  out  1  shared-memory write enable.
REQ-019 SHALL have port bus_addr  out  32  shared-memory address.
REQ-020 SHALL have port bus_wdata  out  32  shared-memory write data.
REQ-021 SHALL have port bus_wstrb  out  4  shared-memory byte enables; 4'b0000 on reads.
REQ-022 SHALL have port bus_rdata  in  32  shared-memory read data, valid with bus_ack.
REQ-023 SHALL have port bus_ack  in  1  one-cycle completion from memory, arbitrary latency ≥ 0 cycles after bus_req rises.

Function
REQ-024 SHALL implement FSM IDLE, BUSY, RESP; IDLE→BUSY on grant, BUSY→RESP on bus_ack, RESP→IDLE unconditionally.
REQ-025 SHALL arbitrate only in IDLE; no request pending → stay IDLE.
REQ-026 SHALL grant data when dm_req=1, unless if_req=1 and starve_cnt==STARVE_LIMIT, in which case fetch is granted.
REQ-027 SHALL grant fetch when if_req=1 and the data request does not win.
REQ-028 SHALL latch owner, address, we, wdata and wstrb into registers on grant; bus_* outputs are driven only from those registers.
REQ-029 SHALL assert bus_req from the cycle after grant through the bus_ack cycle inclusive; bus_* SHALL stay stable while bus_req=1.
REQ-030 SHALL ignore bus_ack outside BUSY.
REQ-031 SHALL capture bus_rdata on bus_ack into if_rdata (fetch owner) or dm_rdata (data load), and pulse if_valid or dm_done during RESP.
REQ-032 SHALL leave dm_rdata unchanged on store completion; SHALL leave the non-owner's rdata unchanged.
REQ-033 SHALL produce stall_f = if_req & ~if_valid and stall_m = dm_req & ~dm_done, combinationally from registered state.
REQ-034 SHALL have minimum transaction latency of 3 cycles (grant, bus with immediate ack, RESP); back-to-back grants are ≥3 cycles apart.
REQ-035 SHALL increment starve_cnt (saturating at STARVE_LIMIT) on each data grant while if_req=1.
REQ-036 SHALL clear starve_cnt on a fetch grant or any IDLE cycle with if_req=0.
REQ-037 SHALL sample requests afresh in IDLE after RESP so a served requester's updated req/address is used and no duplicate access occurs.

Reset
REQ-038 SHALL on rst=1 at a clock edge force state=IDLE, starve_cnt=0, bus_req=0, bus_we=0, bus_addr/bus_wdata=0, bus_wstrb=0, if_rdata=0, dm_rdata=0, if_valid=0, dm_done=0.
REQ-039 SHALL abandon an in-flight transaction on reset mid-BUSY, with no completion pulse; a later stray bus_ack is ignored per REQ-030.

Structure
REQ-040 SHALL take the state encoding (IDLE/BUSY/RESP), owner encoding (FETCH/DATA), XLEN=32 and the STARVE_LIMIT default from the shared pipeline package.
REQ-041 SHALL be a single module; no sub-module is warranted.

Verification
REQ-042 SHALL cover fetch-only: if_req=1, if_addr=0x0000_0010, ack 2 cycles after bus_req, bus_rdata=0x0000_0093 → bus_addr=0x10, if_valid pulse in RESP, if_rdata=0x93, stall_f low that cycle.
REQ-043 SHALL cover simultaneous requests: if_req=dm_req=1, dm_we=0, dm_addr=0x100 → data granted first; fetch granted on next IDLE.
REQ-044 SHALL cover starvation: dm_req held high with 6 back-to-back loads, if_req=1, STARVE_LIMIT=4 → 4 data grants, then 1 fetch grant, then data resumes.
REQ-045 SHALL cover store: dm_we=1, dm_addr=0x200, dm_wdata=0xDEADBEEF, dm_wstrb=4'b0011, ack 0 cycles → bus_wstrb=0011 stable until ack, dm_done pulse, dm_rdata unchanged.
REQ-046 SHALL cover reset mid-BUSY: rst=1 before ack, then bus_ack=1 → bus_req=0 next cycle, no if_valid/dm_done pulse, state IDLE.
